// File: rtl/sdrc_wb_pkg.sv
// Shared definitions for the Wishbone command master.
//   state_e      : burst FSM states (idle, waiting for write data, bus request).
//   DefaultTmo   : default ack timeout in cycles.
//   DefaultLenW  : default width of the burst length field.
package sdrc_wb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWdata = 2'd1,
        StReq   = 2'd2
    } state_e;

    localparam int unsigned DefaultTmo  = 255;
    localparam int unsigned DefaultLenW = 8;

endpackage

// File: rtl/wb_tmo_cnt.sv
// Loadable ack-timeout down-counter.
//   clk_i     : clock, rising edge
//   rst_ni    : synchronous active-low reset
//   load_i    : reload with Tmo-1 (bus request entry or ack)
//   en_i      : count while a bus request is outstanding
//   expired_o : Tmo cycles have elapsed since the last load while enabled
module wb_tmo_cnt #(
    parameter int unsigned Tmo  = 255,
    parameter int unsigned CntW = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CntW-1:0] LoadVal = CntW'(Tmo - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with Tmo-1, so reaching zero marks the Tmo-th cycle in request.
    assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone burst master driven by a simple command/data stream interface.
//   wb_clk_i, wb_resetn               : clock and synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_we/
//   cmd_addr/cmd_len                  : burst command (len is beats minus one)
//   wdata_valid/wdata_ready/wdata     : write data stream, one word per beat
//   rdata_valid/rdata                 : read data stream, no backpressure
//   done/err                          : end-of-burst pulse, err marks timeout abort
//   wb_*                              : Wishbone master bus (classic, registered outputs)
module wb_cmd_master
    import sdrc_wb_pkg::*;
#(
    parameter int unsigned APP_AW = 26,
    parameter int unsigned dw     = 32,
    parameter int unsigned LEN_W  = DefaultLenW,
    parameter int unsigned TMO    = DefaultTmo
) (
    input  logic              wb_clk_i,
    input  logic              wb_resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [dw-1:0]     wdata,
    output logic              rdata_valid,
    output logic [dw-1:0]     rdata,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic              wb_cti_o,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic              wb_ack_i
);

    localparam logic [APP_AW-1:0] AddrStep = APP_AW'(dw / 8);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;

    logic              cmd_ready_d, wdata_ready_d, rdata_valid_d, done_d, err_d;
    logic              cyc_d, stb_d, we_d, cti_d;
    logic [APP_AW-1:0] addr_d;
    logic [dw-1:0]     dat_d, rdata_d;
    logic [dw/8-1:0]   sel_d;

    logic accept, wr_take, ack_req, last_beat, tmo_exp, tmo_load;

    assign accept    = (state_q == StIdle) && cmd_valid && cmd_ready;
    assign wr_take   = (state_q == StWdata) && wdata_valid && wdata_ready;
    assign ack_req   = (state_q == StReq) && wb_ack_i;
    assign last_beat = (beat_q == len_q);
    // Restart the timeout on every fresh request phase, including read beats after an ack.
    assign tmo_load  = (state_d == StReq) && ((state_q != StReq) || wb_ack_i);

    wb_tmo_cnt #(
        .Tmo  (TMO),
        .CntW (16)
    ) u_tmo (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_resetn),
        .load_i    (tmo_load),
        .en_i      (state_q == StReq),
        .expired_o (tmo_exp)
    );

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack always beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = cmd_we ? StWdata : StReq;
            StWdata: if (wr_take) state_d = StReq;
            StReq: begin
                if (wb_ack_i) begin
                    if (last_beat)    state_d = StIdle;
                    else if (wb_we_o) state_d = StWdata;
                    else              state_d = StReq;
                end else if (tmo_exp) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and burst bookkeeping.
    always_comb begin
        len_d         = len_q;
        beat_d        = beat_q;
        addr_d        = wb_addr_o;
        dat_d         = wb_dat_o;
        we_d          = wb_we_o;
        rdata_d       = rdata;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;

        if (accept) begin
            len_d  = cmd_len;
            beat_d = '0;
            addr_d = cmd_addr;
            we_d   = cmd_we;
        end
        if (wr_take) begin
            dat_d = wdata;
        end
        if (ack_req) begin
            if (!wb_we_o) begin
                rdata_d       = wb_dat_i;
                rdata_valid_d = 1'b1;
            end
            if (last_beat) begin
                done_d = 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
                addr_d = wb_addr_o + AddrStep;
            end
        end else if ((state_q == StReq) && tmo_exp) begin
            done_d = 1'b1;
            err_d  = 1'b1;
        end
        if (state_d == StIdle) begin
            we_d = 1'b0;
        end

        cyc_d         = (state_d != StIdle);
        stb_d         = (state_d == StReq);
        sel_d         = cyc_d ? '1 : '0;
        cti_d         = cyc_d && (beat_d != len_d);
        wdata_ready_d = (state_d == StWdata);
        cmd_ready_d   = (state_d == StIdle);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_resetn) begin
            len_q       <= '0;
            beat_q      <= '0;
            cmd_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_addr_o   <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            wb_cti_o    <= 1'b0;
        end else begin
            len_q       <= len_d;
            beat_q      <= beat_d;
            cmd_ready   <= cmd_ready_d;
            wdata_ready <= wdata_ready_d;
            rdata_valid <= rdata_valid_d;
            rdata       <= rdata_d;
            done        <= done_d;
            err         <= err_d;
            wb_cyc_o    <= cyc_d;
            wb_stb_o    <= stb_d;
            wb_we_o     <= we_d;
            wb_addr_o   <= addr_d;
            wb_dat_o    <= dat_d;
            wb_sel_o    <= sel_d;
            wb_cti_o    <= cti_d;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int unsigned APP_AW = 26;
    localparam int unsigned DW     = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned TMO    = 4;
    localparam int unsigned SW     = DW / 8;

    logic              wb_clk_i = 1'b0;
    logic              wb_resetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_we = 1'b0;
    logic [APP_AW-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              wdata_valid = 1'b0;
    logic              wdata_ready;
    logic [DW-1:0]     wdata = '0;
    logic              rdata_valid;
    logic [DW-1:0]     rdata;
    logic              done, err;
    logic              wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o;
    logic [APP_AW-1:0] wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [SW-1:0]     wb_sel_o;
    logic [DW-1:0]     wb_dat_i = '0;
    logic              wb_ack_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    wb_cmd_master #(
        .APP_AW (APP_AW),
        .dw     (DW),
        .LEN_W  (LEN_W),
        .TMO    (TMO)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_resetn   (wb_resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .done        (done),
        .err         (err),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_addr_o   (wb_addr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_cti_o    (wb_cti_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one burst as command source and Wishbone slave. Expectations come from
    // the burst rules: beat i is at (addr + 4*i) mod 2^APP_AW, cti high except the
    // last beat, an unacked beat aborts after exactly TMO strobe cycles.
    //   starve_beat : beat index that is never acked (-1 none)
    //   fixed_k     : strobe cycles before ack (-1 random in 0..TMO-1)
    //   fixed_wdly  : cycles before write data is offered (-1 random)
    //   reset_beat  : beat index at whose first strobe cycle reset is applied (-1 none)
    task automatic run_burst(input logic we, input logic [APP_AW-1:0] addr, input int len,
                             input int starve_beat, input int fixed_k, input int fixed_wdly,
                             input int reset_beat);
        logic [APP_AW-1:0] exp_addr;
        logic [DW-1:0]     wd_cur;
        logic [DW-1:0]     rd;
        int                waited, k, wdly, stb_cycles;
        bit                acked;

        wd_cur = '0;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge wb_clk_i);
            waited++;
        end
        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        @(negedge wb_clk_i);
        // Keep a junk command presented while busy; it must not be taken.
        cmd_we   = 1'($urandom);
        cmd_addr = APP_AW'($urandom);
        cmd_len  = LEN_W'($urandom);
        check_eq("cyc_after_accept", wb_cyc_o, 1);

        for (int i = 0; i <= len; i++) begin
            exp_addr = addr + APP_AW'(i * SW);
            if (we) begin
                wdly = (fixed_wdly >= 0) ? fixed_wdly : int'($urandom_range(0, 3));
                for (int c = 0; c < wdly; c++) begin
                    check_eq("wdata_ready", wdata_ready, 1);
                    check_eq("stb_in_wdata", wb_stb_o, 0);
                    check_eq("cyc_in_wdata", wb_cyc_o, 1);
                    check_eq("rdata_valid_wr", rdata_valid, 0);
                    wb_ack_i = 1'($urandom);  // stray ack, must be ignored here
                    @(negedge wb_clk_i);
                end
                wb_ack_i = 1'b0;
                check_eq("wdata_ready", wdata_ready, 1);
                check_eq("stb_in_wdata", wb_stb_o, 0);
                wdata_valid = 1'b1;
                wdata       = $urandom;
                wd_cur      = wdata;
                @(negedge wb_clk_i);
                wdata_valid = 1'b0;
                wdata       = $urandom;
            end

            k  = (fixed_k >= 0) ? fixed_k : int'($urandom_range(0, TMO - 1));
            if (i == starve_beat) k = TMO + 10;
            rd = $urandom;
            stb_cycles = 0;
            acked = 1'b0;
            while (1) begin
                stb_cycles++;
                check_eq("stb", wb_stb_o, 1);
                check_eq("cyc", wb_cyc_o, 1);
                check_eq("addr", wb_addr_o, exp_addr);
                check_eq("we", wb_we_o, we);
                check_eq("cti", wb_cti_o, (i != len));
                check_eq("sel", wb_sel_o, {SW{1'b1}});
                if (we) check_eq("dat_o", wb_dat_o, wd_cur);
                check_eq("cmd_ready_busy", cmd_ready, 0);
                check_eq("done_busy", done, 0);
                if (!(stb_cycles == 1 && i > 0 && !we))
                    check_eq("rdata_valid_quiet", rdata_valid, 0);
                if (i == reset_beat) begin
                    wb_resetn = 1'b0;
                    cmd_valid = 1'b0;
                    @(negedge wb_clk_i);
                    check_eq("rst_cyc", wb_cyc_o, 0);
                    check_eq("rst_stb", wb_stb_o, 0);
                    check_eq("rst_done", done, 0);
                    check_eq("rst_cmd_ready", cmd_ready, 0);
                    wb_resetn = 1'b1;
                    @(negedge wb_clk_i);
                    check_eq("rel_cmd_ready", cmd_ready, 1);
                    check_eq("rel_done", done, 0);
                    check_eq("rel_cyc", wb_cyc_o, 0);
                    return;
                end
                if (stb_cycles - 1 == k) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = rd;
                    acked    = 1'b1;
                end
                @(negedge wb_clk_i);
                wb_ack_i = 1'b0;
                wb_dat_i = $urandom;
                if (acked) break;
                if (stb_cycles == int'(TMO)) break;
            end

            if (!acked) begin
                cmd_valid = 1'b0;
                check_eq("tmo_cyc", wb_cyc_o, 0);
                check_eq("tmo_stb", wb_stb_o, 0);
                check_eq("tmo_done", done, 1);
                check_eq("tmo_err", err, 1);
                check_eq("tmo_rdata_valid", rdata_valid, 0);
                check_eq("tmo_cmd_ready", cmd_ready, 1);
                @(negedge wb_clk_i);
                check_eq("tmo_done_pulse", done, 0);
                return;
            end

            if (!we) begin
                check_eq("rdata_valid", rdata_valid, 1);
                check_eq("rdata", rdata, rd);
            end
            if (i == len) begin
                cmd_valid = 1'b0;
                check_eq("end_done", done, 1);
                check_eq("end_err", err, 0);
                check_eq("end_cyc", wb_cyc_o, 0);
                check_eq("end_stb", wb_stb_o, 0);
                check_eq("end_cmd_ready", cmd_ready, 1);
                @(negedge wb_clk_i);
                check_eq("done_pulse", done, 0);
                check_eq("rdata_valid_pulse", rdata_valid, 0);
            end
        end
    endtask

    initial begin
        logic [APP_AW-1:0] raddr;
        int                rlen, rstarve;

        wb_resetn = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check_eq("rst_cyc", wb_cyc_o, 0);
        check_eq("rst_stb", wb_stb_o, 0);
        check_eq("rst_we", wb_we_o, 0);
        check_eq("rst_cti", wb_cti_o, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rdata_valid", rdata_valid, 0);
        check_eq("rst_wdata_ready", wdata_ready, 0);
        check_eq("rst_addr", wb_addr_o, 0);
        check_eq("rst_dat", wb_dat_o, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_sel", wb_sel_o, 0);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        wb_resetn = 1'b1;
        @(negedge wb_clk_i);
        check_eq("first_cmd_ready", cmd_ready, 1);

        // Read burst of 4, ack one cycle after each strobe
        run_burst(1'b0, 26'h100, 3, -1, 1, -1, -1);
        // Write burst of 2 with write data held off 5 cycles per beat
        run_burst(1'b1, 26'h200, 1, -1, -1, 5, -1);
        // Timeout on first beat of a read
        run_burst(1'b0, 26'h40, 2, 0, -1, -1, -1);
        // Ack lands on the expiry cycle
        run_burst(1'b0, 26'h80, 1, -1, int'(TMO) - 1, -1, -1);
        run_burst(1'b1, 26'h84, 1, -1, int'(TMO) - 1, -1, -1);
        // Address wrap
        run_burst(1'b0, 26'h3FFFFFC, 1, -1, -1, -1, -1);
        run_burst(1'b1, 26'h3FFFFFC, 1, -1, -1, -1, -1);
        // Timeout on second beat of a write
        run_burst(1'b1, 26'h300, 2, 1, -1, -1, -1);
        // Reset during beat 2 of 4, then a fresh burst
        run_burst(1'b0, 26'h400, 3, -1, 0, -1, 1);
        run_burst(1'b0, 26'h500, 2, -1, -1, -1, -1);

        for (int n = 0; n < 40; n++) begin
            raddr   = APP_AW'($urandom) & ~APP_AW'(3);
            rlen    = int'($urandom_range(0, 5));
            rstarve = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rlen)) : -1;
            run_burst(1'($urandom), raddr, rlen, rstarve, -1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter APP_AW, default 26, Wishbone byte address width.
REQ-002 Parameter dw, default 32, Wishbone data width.
REQ-003 Parameter LEN_W, default 8, burst length field width.
REQ-004 Parameter TMO, default 255, ack timeout in cycles (1..65535).
REQ-005 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 wb_resetn  in  1  reset, synchronous, active-low.
REQ-007 cmd_valid / cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  in  APP_AW  start byte address, word-aligned.
REQ-010 cmd_len  in  LEN_W  beats minus one.
REQ-011 wdata_valid / wdata_ready / wdata  in/out/in  1/1/dw  write-data stream.
REQ-012 rdata_valid / rdata  out/out  1/dw  read-data stream, no backpressure.
REQ-013 done / err  out/out  1/1  end-of-burst pulse; err qualifies done as timeout abort.
REQ-014 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe, direction.
REQ-015 wb_addr_o  out  APP_AW  Wishbone address; wb_dat_o out dw; wb_sel_o out dw/8.
REQ-016 wb_cti_o  out  1  1 = more beats follow, 0 = final beat.
REQ-017 wb_dat_i  in  dw; wb_ack_i  in  1.

Function
REQ-018 Registered outputs; states IDLE, WDATA, REQ.
REQ-019 IDLE: cmd_ready=1; on cmd_valid, latch addr/len/we, clear beat_cnt, go WDATA if write, else REQ.
REQ-020 WDATA: wdata_ready=1, wb_cyc_o=1, wb_stb_o=0; on wdata_valid, load wb_dat_o, go REQ.
REQ-021 REQ: wb_cyc_o=wb_stb_o=1, wb_sel_o all ones, wb_we_o=latched we; hold all bus outputs stable until wb_ack_i.
REQ-022 wb_cti_o = (beat_cnt != len) throughout each beat.
REQ-023 On ack with beat_cnt==len: drop cyc/stb next edge, pulse done=1, err=0 for one cycle, go IDLE.
REQ-024 On ack with beat_cnt<len: beat_cnt+1, wb_addr_o += dw/8 modulo 2^APP_AW; read stays REQ (stb held), write goes WDATA.
REQ-025 Read ack: rdata<=wb_dat_i and rdata_valid=1 on the next cycle, exactly one pulse per acked beat.
REQ-026 Timeout counter clears on REQ entry and on each ack; if TMO cycles elapse in REQ without ack, drop cyc/stb, pulse done=1 and err=1, go IDLE; remaining beats dropped.
REQ-027 Ack and timeout expiry in the same cycle: ack wins.
REQ-028 wb_ack_i outside REQ ignored; cmd_valid outside IDLE not accepted (cmd_ready=0).
REQ-029 WDATA has no timeout; wb_cyc_o held while waiting.
REQ-030 Back-to-back: new command accepted in IDLE the cycle after done; wb_cyc_o low at least one cycle between bursts.

Reset
REQ-031 wb_resetn=0 at a clock edge: state IDLE; cyc/stb/we/cti/done/err/rdata_valid/wdata_ready=0; addr/dat/rdata/beat_cnt/timeout=0; wb_sel_o=0; cmd_ready=0 during reset, 1 on first cycle after release.
REQ-032 Reset mid-burst aborts immediately, no done pulse; bus released on that edge.

Structure
REQ-033 State enum and default TMO/LEN_W constants in shared package sdrc_wb_pkg.
REQ-034 One sub-module natural: wb_tmo_cnt (loadable timeout down-counter with expiry flag).

Verification
REQ-035 Read burst addr=0x100, len=3, ack 1 cycle after each stb -> wb_addr_o 0x100,0x104,0x108,0x10C; cti 1,1,1,0; 4 rdata_valid pulses; done, err=0.
REQ-036 Write len=1, wdata valid delayed 5 cycles -> stb low in WDATA, cyc held; 2 acked beats with correct wb_dat_o; done.
REQ-037 TMO=4, read, no ack -> stb high 4 cycles then cyc/stb low; done=1, err=1; rdata_valid never.
REQ-038 Ack arrives on the expiry cycle -> beat completes normally, err=0.
REQ-039 Address wrap: APP_AW=26, addr=0x3FFFFFC, len=1 -> second beat at 0x0000000.
REQ-040 wb_resetn low during beat 2 of 4 -> cyc/stb low next edge, no done; fresh command after release runs cleanly.
